nes_controller_reader: RTL and testbench
========================================

Name: nes_controller_reader

Overview:
- Replaces the stubbed NES latch/clock in the top level with a real serial controller reader.
- Once per frame it pulses NES latch, clocks 8 serial bits out of the controller, and presents a registered, active-high button vector plus newly-pressed edges.
- Sits directly upstream of the input collector / player logic; started by the sync generator's frame_end pulse.

Parameters:
- HALF_PERIOD, 150, clk cycles per NES half-period "tick" (6 us at 25 MHz); legal range 4..1023.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  one-cycle request to poll the controller (frame_end)
- nes_data  in  1  serial data from controller, active-low, asynchronous
- nes_latch  out  1  latch pulse to controller
- nes_clk  out  1  shift clock to controller
- buttons  out  8  active-high state {Right,Left,Down,Up,Start,Select,B,A}; bit0 = A
- pressed  out  8  buttons newly pressed this poll; valid only while valid=1
- valid  out  1  one-cycle pulse: buttons/pressed updated
- busy  out  1  high from the cycle after start acceptance until valid
- present  out  1  controller-connected flag

Behaviour:
- Reset: rst_n is synchronous and active-low; clk is the clock. All outputs are 0 except present=1. State is IDLE, and the tick counter, bit index and shift register are all 0.
- nes_data passes through a 2-FF synchroniser. Only the synchronised value is sampled.
- Tick counter: counts 0..HALF_PERIOD-1. It clears on every state entry. A tick ends when the count = HALF_PERIOD-1.
- IDLE:
  - nes_latch=0, nes_clk=0.
  - If start=1, go to LATCH on the next cycle (cycle 0 = start cycle).
- LATCH:
  - nes_latch=1 for 2 ticks, then go to LOW with bit index 0.
- LOW:
  - nes_clk=0 for 1 tick.
  - On the last cycle of the tick, shift the synchronised nes_data into shift[index].
  - If index=7, go to DONE; otherwise go to HIGH.
- HIGH:
  - nes_clk=1 for 1 tick.
  - Then index++ and go to LOW.
- DONE (1 cycle), all registered with valid=1:
  - buttons <= ~shift
  - pressed <= ~shift & ~buttons_prev
  - Then go to IDLE.
- Latency: valid asserts on cycle 17*HALF_PERIOD+1 after the start cycle (2 latch + 8 low + 7 high ticks).
- busy=1 in LATCH/LOW/HIGH/DONE.
- start while busy is ignored; there is no queueing.
- start arriving in the same cycle as DONE is ignored. The next poll requires start in IDLE.
- pressed is forced to 0 on every cycle where valid=0.
- buttons holds its value between polls.
- Reset mid-poll: returns to IDLE on the next edge with nes_latch/nes_clk low. buttons is cleared, and no valid is emitted.
- Widths:
  - Tick counter: 10 bits.
  - Index: 3 bits; wraps only by reset or DONE.

Optional Feature:
- Macro NES_PRESENCE_DETECT_EN.
- Defined: in DONE, if shift==8'h00 (every button "pressed", an impossible pattern that indicates an unplugged controller with a pulled-low line):
  - present <= 0
  - buttons <= 0
  - pressed <= 0
  - Any other shift value sets present <= 1 and updates normally.
- Undefined: present is constant 1, and shift==8'h00 decodes as all buttons pressed.

Decomposition:
- Shared package nes_pkg:
  - Button bit index constants: BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7.
  - State encoding: IDLE, LATCH, LOW, HIGH, DONE.
  - NES_BITS=8.
- Sub-module nes_tick_gen: parameterised HALF_PERIOD prescaler with clear input and tick output. The FSM and shift register stay in the parent.

Test Plan (HALF_PERIOD=4 unless noted):
- Idle after reset: rst_n low 3 cycles, then high with no start -> nes_latch=0, nes_clk=0, buttons=0, valid=0, busy=0, present=1 indefinitely.
- Single poll, only A pressed (model drives data=0 for bit0, 1 otherwise):
  - Start at cycle 0 -> nes_latch high for cycles 1–8, 7 nes_clk high pulses of 4 cycles each.
  - valid on cycle 69 with buttons=8'h01 and pressed=8'h01.
- Repeat poll, A held, Up newly pressed -> buttons=8'h11, pressed=8'h10.
- Start pulses during busy (cycles 5 and 40) -> exactly one valid, at cycle 69. Same for HALF_PERIOD=150: valid at cycle 2551.
- rst_n low at cycle 30 mid-poll -> next edge: IDLE, lines low, buttons=0, no valid. A subsequent start completes normally.
- Model data held 0 for all bits:
  - With NES_PRESENCE_DETECT_EN -> present=0, buttons=0.
  - Without it -> buttons=8'hFF, present=1.

Source files
------------

// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the NES controller reader: controller bit order,
// serial frame length and the reader FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package nes_pkg;

    // Bit positions in the button vector; the controller shifts A out first.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NES_BITS   = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } nes_state_e;

endpackage

// File: rtl/nes_tick_gen.sv
// -----------------------------------------------------------------------------
// nes_tick_gen
// Half-period prescaler for the NES serial interface. Counts 0..HALF_PERIOD-1
// and flags the last cycle of each half-period.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   clear  in   restart the count at 0 on the next cycle
//   tick   out  high on the last cycle of a half-period (count = HALF_PERIOD-1)
//
// Parameters:
//   HALF_PERIOD  clk cycles per half-period, legal range 4..1023
// -----------------------------------------------------------------------------
module nes_tick_gen #(
    parameter int HALF_PERIOD = 150
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [9:0] TERMINAL = 10'(HALF_PERIOD - 1);

    logic [9:0] cnt_q;
    logic [9:0] cnt_d;

    assign tick = (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q + 10'd1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nes_controller_reader.sv
// -----------------------------------------------------------------------------
// nes_controller_reader
// Once per start request, pulses the NES latch, clocks eight serial bits out of
// the controller and presents a registered active-high button vector together
// with the buttons newly pressed since the previous poll.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   start      in   one-cycle poll request (frame_end); honoured only in IDLE
//   nes_data   in   controller serial data, active-low, asynchronous
//   nes_latch  out  latch pulse to controller (2 half-periods)
//   nes_clk    out  shift clock to controller (7 high pulses)
//   buttons    out  {Right,Left,Down,Up,Start,Select,B,A}, active-high, held
//   pressed    out  newly pressed buttons, nonzero only while valid=1
//   valid      out  one-cycle pulse when buttons/pressed are updated
//   busy       out  high while a poll is in progress (LATCH..DONE)
//   present    out  controller-connected flag
//
// Parameters:
//   HALF_PERIOD  clk cycles per half-period tick, legal range 4..1023
//
// Build option:
//   NES_PRESENCE_DETECT_EN  when defined, an all-zero serial frame (line held
//                           low, no controller) clears present and reports
//                           no buttons instead of all buttons pressed.
//
// FSM states:
//   state | meaning
//   IDLE  | lines low, waiting for start
//   LATCH | nes_latch high for two half-periods
//   LOW   | nes_clk low for one half-period; sample bit at its last cycle
//   HIGH  | nes_clk high for one half-period; advance bit index
//   DONE  | one cycle; valid high with the freshly decoded vectors
// -----------------------------------------------------------------------------
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int HALF_PERIOD = 150
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                nes_data,
    output logic                nes_latch,
    output logic                nes_clk,
    output logic [NES_BITS-1:0] buttons,
    output logic [NES_BITS-1:0] pressed,
    output logic                valid,
    output logic                busy,
    output logic                present
);

    localparam logic [2:0] LAST_IDX = 3'(NES_BITS - 1);

    nes_state_e          state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [NES_BITS-1:0] shift_q, shift_d;
    logic [NES_BITS-1:0] shift_next;
    logic                latch_half_q, latch_half_d;
    logic                sync1_q, sync2_q;
    logic                nes_latch_q, nes_latch_d;
    logic                nes_clk_q, nes_clk_d;
    logic [NES_BITS-1:0] buttons_q, buttons_d;
    logic [NES_BITS-1:0] pressed_q, pressed_d;
    logic                valid_q, valid_d;
    logic                tick;
    logic                tick_clr;
`ifdef NES_PRESENCE_DETECT_EN
    logic                present_q, present_d;
`endif

    // The counter is held at 0 in IDLE and restarted on every state change,
    // so each state sees whole half-periods starting from count 0.
    assign tick_clr = (state_q == IDLE) || (state_d != state_q);

    nes_tick_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        latch_half_d = latch_half_q;
        buttons_d    = buttons_q;
        pressed_d    = '0;
        valid_d      = 1'b0;
`ifdef NES_PRESENCE_DETECT_EN
        present_d    = present_q;
`endif

        shift_next         = shift_q;
        shift_next[idx_q]  = sync2_q;

        unique case (state_q)
            IDLE: begin
                latch_half_d = 1'b0;
                if (start) begin
                    state_d = LATCH;
                end
            end

            LATCH: begin
                if (tick) begin
                    if (latch_half_q) begin
                        latch_half_d = 1'b0;
                        idx_d        = '0;
                        state_d      = LOW;
                    end else begin
                        latch_half_d = 1'b1;
                    end
                end
            end

            LOW: begin
                if (tick) begin
                    shift_d = shift_next;
                    if (idx_q == LAST_IDX) begin
                        // Decode on the edge into DONE so the registered
                        // vectors and valid are all visible during DONE.
                        state_d = DONE;
                        valid_d = 1'b1;
`ifdef NES_PRESENCE_DETECT_EN
                        if (shift_next == '0) begin
                            present_d = 1'b0;
                            buttons_d = '0;
                            pressed_d = '0;
                        end else begin
                            present_d = 1'b1;
                            buttons_d = ~shift_next;
                            pressed_d = ~shift_next & ~buttons_q;
                        end
`else
                        buttons_d = ~shift_next;
                        pressed_d = ~shift_next & ~buttons_q;
`endif
                    end else begin
                        state_d = HIGH;
                    end
                end
            end

            HIGH: begin
                if (tick) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = LOW;
                end
            end

            DONE: begin
                // A start coinciding with DONE is dropped deliberately.
                idx_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Lines are registered from the next state so they stay glitch-free.
        nes_latch_d = (state_d == LATCH);
        nes_clk_d   = (state_d == HIGH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shift_q      <= '0;
            latch_half_q <= 1'b0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            nes_latch_q  <= 1'b0;
            nes_clk_q    <= 1'b0;
            buttons_q    <= '0;
            pressed_q    <= '0;
            valid_q      <= 1'b0;
`ifdef NES_PRESENCE_DETECT_EN
            present_q    <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            latch_half_q <= latch_half_d;
            sync1_q      <= nes_data;
            sync2_q      <= sync1_q;
            nes_latch_q  <= nes_latch_d;
            nes_clk_q    <= nes_clk_d;
            buttons_q    <= buttons_d;
            pressed_q    <= pressed_d;
            valid_q      <= valid_d;
`ifdef NES_PRESENCE_DETECT_EN
            present_q    <= present_d;
`endif
        end
    end

    assign nes_latch = nes_latch_q;
    assign nes_clk   = nes_clk_q;
    assign buttons   = buttons_q;
    assign pressed   = pressed_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);
`ifdef NES_PRESENCE_DETECT_EN
    assign present   = present_q;
`else
    assign present   = 1'b1;
`endif

endmodule

// File: tb/tb_nes_controller_reader.sv
module tb_nes_controller_reader;

    localparam int HP     = 4;
    localparam int HP_BIG = 150;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_clk;
    logic [7:0] buttons;
    logic [7:0] pressed;
    logic       valid;
    logic       busy;
    logic       present;

    logic       start150;
    logic       nes_data150;
    logic       nes_latch150;
    logic       nes_clk150;
    logic [7:0] buttons150;
    logic [7:0] pressed150;
    logic       valid150;
    logic       busy150;
    logic       present150;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;

    // Controller model: a 4021-style parallel-in shift register.
    logic [7:0] pad       = 8'h00;
    logic       unplugged = 1'b0;
    logic [7:0] pad_l     = 8'h00;
    logic [3:0] bitpos    = 4'd0;

    nes_controller_reader #(.HALF_PERIOD(HP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .nes_data (nes_data),
        .nes_latch(nes_latch),
        .nes_clk  (nes_clk),
        .buttons  (buttons),
        .pressed  (pressed),
        .valid    (valid),
        .busy     (busy),
        .present  (present)
    );

    nes_controller_reader #(.HALF_PERIOD(HP_BIG)) dut150 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start150),
        .nes_data (nes_data150),
        .nes_latch(nes_latch150),
        .nes_clk  (nes_clk150),
        .buttons  (buttons150),
        .pressed  (pressed150),
        .valid    (valid150),
        .busy     (busy150),
        .present  (present150)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge nes_latch or posedge nes_clk) begin
        if (nes_latch) begin
            pad_l  = pad;
            bitpos = 4'd0;
        end else if (bitpos < 4'd8) begin
            bitpos = bitpos + 4'd1;
        end
    end

    assign nes_data = unplugged ? 1'b0 :
                      (bitpos < 4'd8) ? ~pad_l[bitpos[2:0]] : 1'b1;

    // Outside a valid pulse, pressed must read zero.
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
        end else begin
            checks++;
            if (pressed !== 8'h00) begin
                failures++;
                $display("FAIL pressed_idle: got %0h required 00 at %0t", pressed, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One poll on the HP=4 instance; checks waveform shape and latency.
    task automatic poll(input logic [7:0] p, input bit unpl, input int x1, input int x2,
                        output logic [7:0] ob, output logic [7:0] op, output logic opres);
        int  n;
        int  lat;
        int  lat_first;
        int  lat_last;
        int  lat_cycles;
        int  clk_cycles;
        int  clk_pulses;
        bit  prev_clk;
        bit  got;
        pad        = p;
        unplugged  = unpl;
        ob         = 8'h00;
        op         = 8'h00;
        opres      = 1'b0;
        lat        = -1;
        lat_first  = -1;
        lat_last   = -1;
        lat_cycles = 0;
        clk_cycles = 0;
        clk_pulses = 0;
        prev_clk   = 1'b0;
        got        = 1'b0;
        n          = 0;
        @(negedge clk);
        start = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            start = (n == x1) || (n == x2);
            if (nes_latch) begin
                if (lat_first < 0) lat_first = n;
                lat_last = n;
                lat_cycles++;
            end
            if (nes_clk) begin
                clk_cycles++;
                if (!prev_clk) clk_pulses++;
            end
            prev_clk = nes_clk;
            if (n == 1) chk("busy_after_start", 32'(busy), 32'd1);
            if (valid) begin
                got   = 1'b1;
                lat   = n;
                ob    = buttons;
                op    = pressed;
                opres = present;
            end
        end
        chk("valid_latency", 32'(lat), 32'(17 * HP + 1));
        chk("latch_first", 32'(lat_first), 32'd1);
        chk("latch_last", 32'(lat_last), 32'(2 * HP));
        chk("latch_cycles", 32'(lat_cycles), 32'(2 * HP));
        chk("clk_high_cycles", 32'(clk_cycles), 32'(7 * HP));
        chk("clk_pulses", 32'(clk_pulses), 32'd7);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("valid_one_cycle", 32'(valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0] pad;
        bit         unpl;
        int         x1;
        int         x2;
        logic [7:0] eb;
        logic [7:0] ep;
        bit         epres;
    } vec_t;

    vec_t       vt [7];
    logic [7:0] ob, op;
    logic       opres;
    logic [7:0] model_prev;
    logic [7:0] rp, shift_m, eb, ep;
    bit         ru, epres;
    int         vc0;
    int         n, lat, v150, clk150_pulses;
    bit         prev150;
    logic [7:0] b150, p150;

    initial begin
        start       = 1'b0;
        start150    = 1'b0;
        nes_data150 = 1'b1;
        rst_n       = 1'b0;

        vt[0] = '{8'h01, 1'b0, 0,  0,  8'h01, 8'h01, 1'b1};
        vt[1] = '{8'h11, 1'b0, 0,  0,  8'h11, 8'h10, 1'b1};
        vt[2] = '{8'h11, 1'b0, 5,  40, 8'h11, 8'h00, 1'b1};
        vt[3] = '{8'h80, 1'b0, 69, 0,  8'h80, 8'h80, 1'b1};
`ifdef NES_PRESENCE_DETECT_EN
        vt[4] = '{8'h00, 1'b1, 0,  0,  8'h00, 8'h00, 1'b0};
`else
        vt[4] = '{8'h00, 1'b1, 0,  0,  8'hFF, 8'h7F, 1'b1};
`endif
        vt[5] = '{8'h00, 1'b0, 0,  0,  8'h00, 8'h00, 1'b1};
        vt[6] = '{8'h5A, 1'b0, 0,  0,  8'h5A, 8'h5A, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {nes_latch, nes_clk, valid, busy, present, buttons},
            {5'b00001, 8'h00});
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", {nes_latch, nes_clk, valid, busy, present, buttons},
                {5'b00001, 8'h00});
        end

        for (int i = 0; i < 7; i++) begin
            vc0 = valid_cnt;
            poll(vt[i].pad, vt[i].unpl, vt[i].x1, vt[i].x2, ob, op, opres);
            chk($sformatf("vec%0d_buttons", i), 32'(ob), 32'(vt[i].eb));
            chk($sformatf("vec%0d_pressed", i), 32'(op), 32'(vt[i].ep));
            chk($sformatf("vec%0d_present", i), 32'(opres), 32'(vt[i].epres));
            chk($sformatf("vec%0d_buttons_hold", i), 32'(buttons), 32'(vt[i].eb));
            if (vt[i].x1 != 0) begin
                repeat (80) @(negedge clk);
                chk($sformatf("vec%0d_single_valid", i), 32'(valid_cnt - vc0), 32'd1);
            end
        end
        model_prev = 8'h5A;

        // Reset in the middle of a poll.
        pad       = 8'h3C;
        unplugged = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 30) rst_n = 1'b0;
            if (c == 31) begin
                chk("midreset_lines", {nes_latch, nes_clk, busy, valid}, 4'b0000);
                chk("midreset_buttons", 32'(buttons), 32'h0);
                rst_n = 1'b1;
            end
        end
        vc0 = valid_cnt;
        repeat (100) @(negedge clk);
        chk("midreset_no_valid", 32'(valid_cnt - vc0), 32'd0);
        poll(8'h3C, 1'b0, 0, 0, ob, op, opres);
        chk("after_reset_buttons", 32'(ob), 32'h3C);
        chk("after_reset_pressed", 32'(op), 32'h3C);
        model_prev = 8'h3C;

        // Random polls against a reference built from the button rules.
        for (int i = 0; i < 16; i++) begin
            rp = 8'($urandom);
            ru = ($urandom_range(0, 5) == 0);
            shift_m = ru ? 8'h00 : ~rp;
            eb    = ~shift_m;
            ep    = eb & ~model_prev;
            epres = 1'b1;
`ifdef NES_PRESENCE_DETECT_EN
            if (shift_m == 8'h00) begin
                eb    = 8'h00;
                ep    = 8'h00;
                epres = 1'b0;
            end
`endif
            model_prev = eb;
            poll(rp, ru, $urandom_range(2, 68), 0, ob, op, opres);
            chk($sformatf("rand%0d_buttons", i), 32'(ob), 32'(eb));
            chk($sformatf("rand%0d_pressed", i), 32'(op), 32'(ep));
            chk($sformatf("rand%0d_present", i), 32'(opres), 32'(epres));
        end
        unplugged = 1'b0;

        // HALF_PERIOD=150 instance with starts during busy.
        @(negedge clk);
        start150      = 1'b1;
        n             = 0;
        v150          = 0;
        lat           = -1;
        clk150_pulses = 0;
        prev150       = 1'b0;
        b150          = 8'hAA;
        p150          = 8'hAA;
        while (n < 3700) begin
            @(negedge clk);
            n++;
            start150 = (n == 5) || (n == 1000);
            if (n == 1) chk("big_busy_latch", {busy150, nes_latch150}, 2'b11);
            if (nes_clk150 && !prev150) clk150_pulses++;
            prev150 = nes_clk150;
            if (valid150) begin
                v150++;
                if (lat < 0) begin
                    lat  = n;
                    b150 = buttons150;
                    p150 = pressed150;
                end
            end
        end
        start150 = 1'b0;
        chk("big_latency", 32'(lat), 32'(17 * HP_BIG + 1));
        chk("big_single_valid", 32'(v150), 32'd1);
        chk("big_clk_pulses", 32'(clk150_pulses), 32'd7);
        chk("big_buttons", {b150, p150}, 16'h0000);
        chk("big_present", 32'(present150), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
